bram1_arbiter: RTL and testbench
================================

Name: bram1_arbiter

Overview:
- Two-requester arbiter and sequencer for one single-port, write-first, 1-cycle-latency block RAM.
- Multiplexes two independent masters onto the RAM's ADDR/DIN/WR/DOUT ports.
- Round-robin fairness, with an optional bounded lock for short atomic bursts.
- Sits between fetch/DMA-style masters and the shared memory instance.

Parameters:
- Ncells, 1024, RAM depth; address width is $clog2(Ncells).
- Wdata, 8, data width.
- Maxburst, 4, max consecutive grants one locked port may hold while the other waits (≥1).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQ0/REQ1  in  1  access request, held until GNT
- WR0/WR1  in  1  1 = write, 0 = read
- LOCK0/LOCK1  in  1  request back-to-back ownership on following cycles
- ADDR0/ADDR1  in  $clog2(Ncells)  address
- DIN0/DIN1  in  Wdata  write data
- GNT0/GNT1  out  1  combinational; access issued to RAM this cycle
- RVALID0/RVALID1  out  1  registered; response for that port's access granted last cycle
- DOUT  out  Wdata  shared response data (= MEM_DOUT)
- MEM_ADDR  out  $clog2(Ncells)  to RAM ADDR
- MEM_DIN  out  Wdata  to RAM DIN
- MEM_WR  out  1  to RAM WR
- MEM_DOUT  in  Wdata  from RAM DOUT

Behaviour:
- Single clock CLK; reset RST is synchronous, active-high.
- State: last-granted pointer LAST (1 bit), OWNER ∈ {NONE, P0, P1}, burst counter CNT (width $clog2(Maxburst+1)).
- Reset values: LAST=1 (port 0 wins the first conflict), OWNER=NONE, CNT=0, RVALID0=RVALID1=0.
- While RST=1: GNT0=GNT1=0 and MEM_WR=0 combinationally.
- At most one GNT per cycle. A port is only granted if its REQ=1.

Grant decision, evaluated combinationally each cycle:
- Locked hold: if OWNER=Pn, REQn=1 and CNT<Maxburst, grant n.
- Single requester: otherwise, if only one port requests, grant it.
- Conflict: otherwise, if both request, grant the port ≠ LAST.
- Idle: no requests → no grant, MEM_WR=0, MEM_ADDR=ADDR0, MEM_DIN=DIN0.

Datapath on grant n:
- MEM_ADDR=ADDRn, MEM_DIN=DINn, MEM_WR=WRn.
- Next edge: LAST<=n.
- OWNER/CNT update:
  - If LOCKn=1 and OWNER=Pn: CNT<=CNT+1.
  - If LOCKn=1 and OWNER≠Pn: OWNER<=Pn, CNT<=1.
  - If LOCKn=0: OWNER<=NONE, CNT<=0.

Lock release and expiry:
- Owner REQ deasserts with no grant that cycle → OWNER<=NONE, CNT<=0.
- CNT==Maxburst with the other port requesting → the other port is granted. OWNER then moves to it if its LOCK=1, else goes to NONE.
- CNT==Maxburst with no other request → the owner is re-granted by the single-requester rule. CNT restarts: OWNER<=Pn, CNT<=1 if LOCKn=1.

Response:
- RVALIDn <= GNTn & ~RST, so latency is exactly 1 cycle after grant.
- DOUT=MEM_DOUT is meaningful only while some RVALID=1.
- Read response is the RAM content; write response echoes the written data (write-first RAM). Both are acknowledged with RVALID.

Boundary cases:
- Both ports may address the same cell on consecutive cycles. Read-after-write returns the new data, with no extra stall.
- Reset mid-burst: the grant is dropped the same cycle, and no RVALID follows next cycle.

Decomposition:
- Shared package holds:
  - the OWNER encoding constants (NONE=2'd0, P0=2'd1, P1=2'd2);
  - the address-width function $clog2(Ncells) used by both this block and the RAM wrapper.
- One natural sub-module: rr_grant2, the combinational 2-way round-robin picker (inputs REQ[1:0], LAST; output one-hot GNT). Lock override stays in the top.

Test Plan:
- Single read: reset, preload cell 5=8'hA5, REQ0=1 WR0=0 ADDR0=5 → GNT0=1 same cycle; next cycle RVALID0=1, DOUT=8'hA5, RVALID1=0.
- Conflict fairness: REQ0=REQ1=1 held 4 cycles, no LOCK → grants 0,1,0,1; RVALID follows each by 1 cycle.
- Write then read: port1 writes 8'h3C to addr 7, port0 reads addr 7 next cycle → port1 RVALID echo 8'h3C; port0 RVALID DOUT=8'h3C.
- Lock burst and expiry: Maxburst=4, LOCK0=REQ0=1 and REQ1=1 continuously → GNT0 4 cycles, GNT1 1 cycle, then GNT0 4 again; port1 is never starved for more than 4 cycles.
- Lock release: LOCK0 drops after 2 grants while REQ1 waits → next cycle GNT1=1, OWNER=NONE.
- Reset mid-operation: assert RST in the cycle GNT1=1 → GNT1 forced 0, MEM_WR=0, no RVALID next cycle, first post-reset conflict grants port 0.

Source files
------------

// File: rtl/bram1_arbiter_pkg.sv
// Shared definitions for the two-port block RAM arbiter and its RAM wrapper.
//   owner_t : which port (if any) currently holds a burst lock
//   addr_w  : address width for a RAM of the given depth
package bram1_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  function automatic int addr_w(input int ncells);
    return $clog2(ncells);
  endfunction

endpackage

// File: rtl/bram1_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared RAM.
//   Requester side : REQn, WRn, LOCKn, ADDRn, DINn -> GNTn, RVALIDn, DOUT
//   RAM side       : MEM_ADDR, MEM_DIN, MEM_WR -> MEM_DOUT
// slave  : the arbiter's view
// master : the requesters' / RAM model's view
interface bram1_arbiter_if #(
  parameter int Ncells = 1024,
  parameter int Wdata  = 8
);
  localparam int AW = bram1_arbiter_pkg::addr_w(Ncells);

  logic             REQ0, REQ1;
  logic             WR0, WR1;
  logic             LOCK0, LOCK1;
  logic [AW-1:0]    ADDR0, ADDR1;
  logic [Wdata-1:0] DIN0, DIN1;
  logic             GNT0, GNT1;
  logic             RVALID0, RVALID1;
  logic [Wdata-1:0] DOUT;
  logic [AW-1:0]    MEM_ADDR;
  logic [Wdata-1:0] MEM_DIN;
  logic             MEM_WR;
  logic [Wdata-1:0] MEM_DOUT;

  modport slave (
    input  REQ0, REQ1, WR0, WR1, LOCK0, LOCK1, ADDR0, ADDR1, DIN0, DIN1, MEM_DOUT,
    output GNT0, GNT1, RVALID0, RVALID1, DOUT, MEM_ADDR, MEM_DIN, MEM_WR
  );

  modport master (
    output REQ0, REQ1, WR0, WR1, LOCK0, LOCK1, ADDR0, ADDR1, DIN0, DIN1, MEM_DOUT,
    input  GNT0, GNT1, RVALID0, RVALID1, DOUT, MEM_ADDR, MEM_DIN, MEM_WR
  );

endinterface

// File: rtl/bram1_arbiter_rr_grant2.sv
// Combinational 2-way round-robin picker.
//   req  : request vector {REQ1, REQ0}
//   last : port granted most recently
//   gnt  : one-hot grant; on a conflict the port other than last wins
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/bram1_arbiter.sv
// Two-requester arbiter for one single-port, write-first, 1-cycle-latency RAM.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : requester handshakes (REQ/WR/LOCK/ADDR/DIN -> GNT/RVALID/DOUT)
//              and the RAM port (MEM_ADDR/MEM_DIN/MEM_WR <- MEM_DOUT)
// Grants are combinational; RVALIDn follows GNTn by exactly one cycle.
// A locking port may hold the RAM for up to Maxburst consecutive grants
// while the other port waits.
//
// owner    | meaning
// OWN_NONE | no burst in progress, plain round-robin
// OWN_P0   | port 0 holds a burst, cnt grants issued so far
// OWN_P1   | port 1 holds a burst, cnt grants issued so far
module bram1_arbiter
  import bram1_arbiter_pkg::*;
#(
  parameter int Ncells   = 1024,
  parameter int Wdata    = 8,
  parameter int Maxburst = 4
) (
  input logic              CLK,
  input logic              RST,
  bram1_arbiter_if.slave   bus
);

  localparam int            AW   = addr_w(Ncells);
  localparam int            CW   = $clog2(Maxburst + 1);
  localparam logic [CW-1:0] MAXC = CW'(Maxburst);

  logic          last_q, last_d;
  owner_t        owner_q, owner_d, owner_g;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rvalid_q;
  logic [1:0]    req, lock, gnt_rr, gnt;
  logic          gsel;
  logic [AW-1:0]    addr_mux;
  logic [Wdata-1:0] din_mux;

  assign req  = {bus.REQ1, bus.REQ0};
  assign lock = {bus.LOCK1, bus.LOCK0};

  rr_grant2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (gnt_rr)
  );

  // Lock hold overrides round-robin until the burst budget is spent.
  always_comb begin
    gnt = 2'b00;
    if (!RST) begin
      if (owner_q == OWN_P0 && req[0] && cnt_q < MAXC)      gnt = 2'b01;
      else if (owner_q == OWN_P1 && req[1] && cnt_q < MAXC) gnt = 2'b10;
      else                                                   gnt = gnt_rr;
    end
  end

  assign gsel     = gnt[1];
  assign owner_g  = gsel ? OWN_P1 : OWN_P0;
  assign addr_mux = gsel ? bus.ADDR1 : bus.ADDR0;
  assign din_mux  = gsel ? bus.DIN1  : bus.DIN0;

  assign bus.GNT0     = gnt[0];
  assign bus.GNT1     = gnt[1];
  assign bus.MEM_ADDR = addr_mux;
  assign bus.MEM_DIN  = din_mux;
  assign bus.MEM_WR   = (gnt != 2'b00) && (gsel ? bus.WR1 : bus.WR0);
  assign bus.RVALID0  = rvalid_q[0];
  assign bus.RVALID1  = rvalid_q[1];
  assign bus.DOUT     = bus.MEM_DOUT;

  // No grant means the owner (if any) dropped its request: release the lock.
  always_comb begin
    last_d  = last_q;
    owner_d = OWN_NONE;
    cnt_d   = '0;
    if (gnt != 2'b00) begin
      last_d = gsel;
      if (lock[gsel]) begin
        owner_d = owner_g;
        // Re-grant after expiry (single requester) restarts the burst count.
        cnt_d   = (owner_q == owner_g && cnt_q < MAXC) ? cnt_q + CW'(1) : CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q   <= 1'b1;
      owner_q  <= OWN_NONE;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt;
    end
  end

endmodule

// File: tb/tb_bram1_arbiter.sv
module tb_bram1_arbiter;
  import bram1_arbiter_pkg::*;

  localparam int NC = 1024;
  localparam int WD = 8;
  localparam int MB = 4;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  bram1_arbiter_if #(.Ncells(NC), .Wdata(WD)) bus ();

  bram1_arbiter #(.Ncells(NC), .Wdata(WD), .Maxburst(MB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 33);
  endfunction

  // Write-first RAM, 1-cycle read latency; unwritten cells hold init_val.
  logic [7:0] ram_d[NC];
  bit         ram_w[NC];
  logic [7:0] ram_q;
  always @(posedge CLK) begin
    if (bus.MEM_WR) begin
      ram_d[bus.MEM_ADDR] <= bus.MEM_DIN;
      ram_w[bus.MEM_ADDR] <= 1'b1;
      ram_q               <= bus.MEM_DIN;
    end else begin
      ram_q <= ram_w[bus.MEM_ADDR] ? ram_d[bus.MEM_ADDR] : init_val(int'(bus.MEM_ADDR));
    end
  end
  assign bus.MEM_DOUT = ram_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: grant rules, burst ownership and shadow memory contents.
  int         m_last = 1;
  int         m_own  = -1;
  int         m_run  = 0;
  bit         m_rv[2];
  logic [7:0] m_dout;
  logic [7:0] sh_d[NC];
  bit         sh_w[NC];

  always @(negedge CLK) begin
    int         g;
    bit         r[2];
    bit         l[2];
    bit         w[2];
    logic [9:0] a[2];
    logic [7:0] d[2];
    r[0] = bus.REQ0;  r[1] = bus.REQ1;
    l[0] = bus.LOCK0; l[1] = bus.LOCK1;
    w[0] = bus.WR0;   w[1] = bus.WR1;
    a[0] = bus.ADDR0; a[1] = bus.ADDR1;
    d[0] = bus.DIN0;  d[1] = bus.DIN1;

    if (RST)                                      g = -1;
    else if (m_own >= 0 && r[m_own] && m_run < MB) g = m_own;
    else if (r[0] && r[1])                        g = 1 - m_last;
    else if (r[0])                                g = 0;
    else if (r[1])                                g = 1;
    else                                          g = -1;

    chk("model_gnt0", 32'(bus.GNT0), 32'(g == 0));
    chk("model_gnt1", 32'(bus.GNT1), 32'(g == 1));
    chk("model_mem_wr", 32'(bus.MEM_WR), 32'((g >= 0) ? w[g] : 1'b0));
    if (!RST) begin
      chk("model_mem_addr", 32'(bus.MEM_ADDR), 32'((g == 1) ? a[1] : a[0]));
      chk("model_mem_din", 32'(bus.MEM_DIN), 32'((g == 1) ? d[1] : d[0]));
    end
    chk("model_rvalid0", 32'(bus.RVALID0), 32'(m_rv[0]));
    chk("model_rvalid1", 32'(bus.RVALID1), 32'(m_rv[1]));
    if (m_rv[0] || m_rv[1]) chk("model_dout", 32'(bus.DOUT), 32'(m_dout));

    m_rv[0] = (g == 0);
    m_rv[1] = (g == 1);
    if (RST) begin
      m_last = 1; m_own = -1; m_run = 0;
    end else if (g < 0) begin
      m_own = -1; m_run = 0;
    end else begin
      m_last = g;
      if (w[g]) begin
        sh_d[a[g]] = d[g];
        sh_w[a[g]] = 1'b1;
        m_dout     = d[g];
      end else begin
        m_dout = sh_w[a[g]] ? sh_d[a[g]] : init_val(int'(a[g]));
      end
      if (!l[g]) begin
        m_own = -1; m_run = 0;
      end else if (m_own == g && m_run < MB) begin
        m_run++;
      end else begin
        m_own = g; m_run = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  task automatic drv(input bit r0, input bit w0, input bit l0, input int a0, input int d0,
                     input bit r1, input bit w1, input bit l1, input int a1, input int d1);
    bus.REQ0 = r0; bus.WR0 = w0; bus.LOCK0 = l0; bus.ADDR0 = 10'(a0); bus.DIN0 = 8'(d0);
    bus.REQ1 = r1; bus.WR1 = w1; bus.LOCK1 = l1; bus.ADDR1 = 10'(a1); bus.DIN1 = 8'(d1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  initial begin
    bit exp_c[4];
    bit exp_b[10];
    checks   = 0;
    failures = 0;
    exp_c = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset: a pending request must not be granted.
    RST = 1'b1;
    drv(1, 1, 0, 5, 8'h11, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    settle();
    chk("rst_gnt0", 32'(bus.GNT0), 32'd0);
    chk("rst_mem_wr", 32'(bus.MEM_WR), 32'd0);
    chk("rst_rvalid0", 32'(bus.RVALID0), 32'd0);

    // Single read of preloaded cell 5.
    cyc();
    RST = 1'b0;
    drv(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rd_gnt0", 32'(bus.GNT0), 32'd1);
    chk("rd_addr", 32'(bus.MEM_ADDR), 32'd5);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rd_rvalid0", 32'(bus.RVALID0), 32'd1);
    chk("rd_dout", 32'(bus.DOUT), 32'h0A5);
    chk("rd_rvalid1", 32'(bus.RVALID1), 32'd0);
    cyc();

    // Conflict fairness without lock.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
      settle();
      chk("rr_gnt0", 32'(bus.GNT0), 32'(exp_c[i]));
      chk("rr_gnt1", 32'(bus.GNT1), 32'(!exp_c[i]));
      if (i > 0) chk("rr_rvalid0", 32'(bus.RVALID0), 32'(exp_c[i-1]));
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rr_last_rvalid1", 32'(bus.RVALID1), 32'd1);
    cyc();

    // Port 1 writes, port 0 reads the same cell next cycle.
    do_reset();
    drv(0, 0, 0, 0, 0, 1, 1, 0, 7, 8'h3C);
    settle();
    chk("wr_gnt1", 32'(bus.GNT1), 32'd1);
    chk("wr_mem_wr", 32'(bus.MEM_WR), 32'd1);
    cyc();
    drv(1, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    settle();
    chk("raw_gnt0", 32'(bus.GNT0), 32'd1);
    chk("wr_rvalid1", 32'(bus.RVALID1), 32'd1);
    chk("wr_echo", 32'(bus.DOUT), 32'h03C);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("raw_rvalid0", 32'(bus.RVALID0), 32'd1);
    chk("raw_dout", 32'(bus.DOUT), 32'h03C);
    cyc();

    // Lock burst and expiry: 4 grants to port 0, 1 to port 1, repeat.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 1, 16 + i, 0, 1, 0, 0, 40 + i, 0);
      settle();
      chk("burst_gnt0", 32'(bus.GNT0), 32'(exp_b[i]));
      chk("burst_gnt1", 32'(bus.GNT1), 32'(!exp_b[i]));
      cyc();
    end

    // Lock release: port 1 gets in right after the lock is dropped.
    do_reset();
    drv(1, 0, 1, 3, 0, 1, 0, 0, 4, 0);
    settle();
    chk("rel_gnt0_a", 32'(bus.GNT0), 32'd1);
    cyc();
    drv(1, 0, 0, 3, 0, 1, 0, 0, 4, 0);
    settle();
    chk("rel_gnt0_b", 32'(bus.GNT0), 32'd1);
    cyc();
    settle();
    chk("rel_gnt1", 32'(bus.GNT1), 32'd1);
    cyc();

    // Reset arriving in the cycle port 1 would write.
    do_reset();
    drv(1, 0, 0, 9, 0, 1, 1, 0, 9, 8'h77);
    settle();
    chk("mid_gnt0", 32'(bus.GNT0), 32'd1);
    cyc();
    RST = 1'b1;
    settle();
    chk("mid_rst_gnt1", 32'(bus.GNT1), 32'd0);
    chk("mid_rst_mem_wr", 32'(bus.MEM_WR), 32'd0);
    cyc();
    RST = 1'b0;
    settle();
    chk("mid_no_rvalid1", 32'(bus.RVALID1), 32'd0);
    chk("mid_post_gnt0", 32'(bus.GNT0), 32'd1);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("mid_cell9_read_back", 32'(bus.DOUT), 32'(init_val(9)));
    cyc();

    // Mixed traffic on overlapping cells with both ports locking.
    for (int i = 0; i < 24; i++) begin
      drv((i % 5) != 4, i[0], i < 12, 20 + (i % 4), i,
          (i % 3) != 0, i[1], 1'b1, 20 + ((i + 1) % 4), 8'h80 + i);
      cyc();
    end
    drv(1, 0, 0, 21, 0, 1, 0, 0, 22, 0);
    cyc();
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
